// File: rtl/add_share_arb_if.sv
// add_share_arb_if -- bundles the requester, shared-adder and response
// channels of add_share_arb.
//   ena                  grant enable
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot)
//   req_a/req_b          packed operands, requester i at [i*W +: W]
//   add_a/add_b          registered operands to the shared adder
//   add_sum/add_cout     combinational result from the shared adder
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_sum/rsp_cout  tagged response payload
//   ovf_count            saturating count of carry-out responses
// slave  : the arbiter side.
// master : the surrounding logic (requesters, adder, response consumer).
interface add_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = 2
);
  logic               ena;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [W-1:0]       add_a;
  logic [W-1:0]       add_b;
  logic [W-1:0]       add_sum;
  logic               add_cout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_sum;
  logic               rsp_cout;
  logic [7:0]         ovf_count;

  modport slave (
    input  ena, req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout,
           ovf_count
  );

  modport master (
    output ena, req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout,
           ovf_count
  );
endinterface

// File: rtl/add_share_arb.sv
// add_share_arb -- round-robin arbiter that time-shares one external W-bit
// adder between N_REQ requesters. A granted operand pair is latched, held on
// add_a/add_b for one cycle, and the adder result is returned on the
// response channel tagged with the requester id.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    add_share_arb_if.slave (request, adder and response channels)
module add_share_arb #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  add_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] gnt_id_reg;
  logic [W-1:0]   op_a_reg, op_b_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [W-1:0]   rsp_sum_reg;
  logic           rsp_cout_reg;
  logic [7:0]     ovf_count_reg;

  logic [W-1:0]   a_arr   [N_REQ];
  logic [W-1:0]   b_arr   [N_REQ];
  logic [IDW-1:0] rot_idx [N_REQ];
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           gnt_fire;

  // Unpack operands and build the search order rr_ptr, rr_ptr+1, ... mod N_REQ.
  // rr_ptr < N_REQ <= 2**IDW, so one conditional subtract is enough to wrap.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [IDW:0] rot_sum;
      assign a_arr[gi]   = bus.req_a[gi*W +: W];
      assign b_arr[gi]   = bus.req_b[gi*W +: W];
      assign rot_sum     = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
      assign rot_idx[gi] = (rot_sum >= (IDW+1)'(N_REQ))
                           ? rot_sum[IDW-1:0] - IDW'(N_REQ)
                           : rot_sum[IDW-1:0];
    end
  endgenerate

  // Walk the search order from the far end so the nearest valid requester
  // is the last (and winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot_idx[k]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rot_idx[k];
      end
    end
  end

  // rst_n gates the strobe so no handshake can complete while in reset.
  assign gnt_fire      = rst_n && (state_reg == IDLE) && bus.ena && gnt_found;
  assign bus.req_ready = gnt_fire ? (N_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_fire) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      gnt_id_reg    <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
      ovf_count_reg <= '0;
    end else begin
      if (gnt_fire) begin
        op_a_reg   <= a_arr[gnt_idx];
        op_b_reg   <= b_arr[gnt_idx];
        gnt_id_reg <= gnt_idx;
        rr_ptr_reg <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // The adder sees op_a/op_b throughout ISSUE; its result is sampled here.
      if (state_reg == ISSUE) begin
        rsp_sum_reg   <= bus.add_sum;
        rsp_cout_reg  <= bus.add_cout;
        rsp_id_reg    <= gnt_id_reg;
        rsp_valid_reg <= 1'b1;
        if (bus.add_cout && (ovf_count_reg != 8'hFF)) begin
          ovf_count_reg <= ovf_count_reg + 8'd1;
        end
      end
      if ((state_reg == RESP) && bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.add_a     = op_a_reg;
  assign bus.add_b     = op_b_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_sum   = rsp_sum_reg;
  assign bus.rsp_cout  = rsp_cout_reg;
  assign bus.ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb -- self-checking bench for add_share_arb: directed vector
// table, hand-written corner sequences, then randomized traffic against a
// round-robin reference model.
module tb_add_share_arb;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_share_arb_if #(.N_REQ(N), .W(W), .IDW(IDW)) ifc ();

  // Shared adder: plain combinational add of the arbiter's operands.
  assign {ifc.add_cout, ifc.add_sum} = {1'b0, ifc.add_a} + {1'b0, ifc.add_b};

  add_share_arb #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int tests = 0;
  int fails = 0;
  int m_rr  = 0;
  int m_ovf = 0;

  typedef struct {
    logic [3:0]  vm;
    logic [31:0] ap;
    logic [31:0] bp;
    int          id;
    logic [7:0]  sum;
    logic        cout;
    int          ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: present requests, wait (bounded) for the grant,
  // check the fixed 2-cycle latency, optionally stall the response, retire.
  task automatic transact(input logic [3:0] vm, input logic [31:0] ap,
                          input logic [31:0] bp, input int stall,
                          output int gid, output int waited,
                          output logic [7:0] s, output logic c, output int rid);
    logic [7:0] ea, eb;
    gid = -1; waited = 0; s = '0; c = 1'b0; rid = -1;
    ifc.req_valid = vm;
    ifc.req_a     = ap;
    ifc.req_b     = bp;
    ifc.rsp_ready = (stall == 0);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (ifc.req_ready != '0) begin
        for (int i = 0; i < N; i++) if (ifc.req_ready[i]) gid = i;
        chk("ready_onehot", 32'($onehot(ifc.req_ready)), 32'd1);
        break;
      end
      waited++;
      tick();
    end
    chk("grant_seen", 32'(gid >= 0), 32'd1);
    if (gid < 0) begin
      ifc.req_valid = '0;
      return;
    end
    ea = ap[gid*8 +: 8];
    eb = bp[gid*8 +: 8];
    tick();
    ifc.req_valid = '0;
    chk("issue_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("add_a", 32'(ifc.add_a), 32'(ea));
    chk("add_b", 32'(ifc.add_b), 32'(eb));
    tick();
    chk("rsp_latency", 32'(ifc.rsp_valid), 32'd1);
    s   = ifc.rsp_sum;
    c   = ifc.rsp_cout;
    rid = int'(ifc.rsp_id);
    ifc.req_valid = 4'hF;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_no_ready", 32'(ifc.req_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(ifc.rsp_valid), 32'd1);
      chk("stall_sum", 32'(ifc.rsp_sum), 32'(s));
      chk("stall_id", 32'(ifc.rsp_id), 32'(rid));
    end
    ifc.req_valid = '0;
    ifc.rsp_ready = 1'b1;
    tick();
    chk("rsp_release", 32'(ifc.rsp_valid), 32'd0);
    $display("[TB] txn mask=%b gnt=%0d a=%02h b=%02h -> id=%0d sum=%02h cout=%0d ovf=%0d",
             vm, gid, ea, eb, rid, s, c, ifc.ovf_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid, w, rid, eg, full;
    logic [7:0] s, ea, eb;
    logic c, en;
    logic [3:0] mask;
    logic [31:0] ap, bp;
    int stall;

    tbl[0]  = '{4'hF,    32'h40302010, 32'h04030201, 0, 8'h11, 1'b0, 0};
    tbl[1]  = '{4'hF,    32'h40302010, 32'h04030201, 1, 8'h22, 1'b0, 0};
    tbl[2]  = '{4'hF,    32'h40302010, 32'h04030201, 2, 8'h33, 1'b0, 0};
    tbl[3]  = '{4'hF,    32'h40302010, 32'h04030201, 3, 8'h44, 1'b0, 0};
    tbl[4]  = '{4'hF,    32'h40302010, 32'h04030201, 0, 8'h11, 1'b0, 0};
    tbl[5]  = '{4'b0010, 32'hFF807F01, 32'h018001FF, 1, 8'h80, 1'b0, 0};
    tbl[6]  = '{4'b1010, 32'hFF807F01, 32'h018001FF, 3, 8'h00, 1'b1, 1};
    tbl[7]  = '{4'b1010, 32'hFF807F01, 32'h018001FF, 1, 8'h80, 1'b0, 1};
    tbl[8]  = '{4'b0001, 32'h00000012, 32'h00000034, 0, 8'h46, 1'b0, 1};
    tbl[9]  = '{4'b0100, 32'h00F00000, 32'h00200000, 2, 8'h10, 1'b1, 2};
    tbl[10] = '{4'b0101, 32'hFF807F01, 32'h018001FF, 0, 8'h00, 1'b1, 3};
    tbl[11] = '{4'b0101, 32'hFF807F01, 32'h018001FF, 2, 8'h00, 1'b1, 4};

    // Reset: outputs cleared and no strobe even with everything requesting.
    ifc.ena = 1'b1; ifc.req_valid = 4'hF; ifc.rsp_ready = 1'b0;
    ifc.req_a = 32'h11111111; ifc.req_b = 32'h22222222;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(ifc.rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(ifc.rsp_sum), 32'd0);
    chk("rst_rsp_cout", 32'(ifc.rsp_cout), 32'd0);
    chk("rst_ovf", 32'(ifc.ovf_count), 32'd0);
    chk("rst_add_a", 32'(ifc.add_a), 32'd0);
    chk("rst_add_b", 32'(ifc.add_b), 32'd0);
    ifc.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Directed vectors: round-robin order, pointer wrap, carries.
    for (int i = 0; i < 12; i++) begin
      transact(tbl[i].vm, tbl[i].ap, tbl[i].bp, 0, gid, w, s, c, rid);
      chk("tbl_gnt", 32'(gid), 32'(tbl[i].id));
      chk("tbl_rsp_id", 32'(rid), 32'(tbl[i].id));
      chk("tbl_sum", 32'(s), 32'(tbl[i].sum));
      chk("tbl_cout", 32'(c), 32'(tbl[i].cout));
      chk("tbl_ovf", 32'(ifc.ovf_count), 32'(tbl[i].ovf));
    end
    m_rr = 3; m_ovf = 4;

    // Backpressure: 5 stall cycles, then the next grant is immediate.
    transact(4'b0001, 32'h0000005A, 32'h000000A5, 5, gid, w, s, c, rid);
    chk("bp_gnt", 32'(gid), 32'd0);
    chk("bp_sum", 32'(s), 32'hFF);
    transact(4'b0100, 32'hFF807F01, 32'h018001FF, 0, gid, w, s, c, rid);
    chk("bp_next_wait", 32'(w), 32'd0);
    chk("bp_next_gnt", 32'(gid), 32'd2);
    chk("bp_next_cout", 32'(c), 32'd1);
    m_ovf = 5;

    // ena gating: nothing accepted while low; grant in the cycle it rises.
    ifc.ena = 1'b0; ifc.req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ena_low_ready", 32'(ifc.req_ready), 32'd0);
      tick();
      chk("ena_low_rsp", 32'(ifc.rsp_valid), 32'd0);
    end
    ifc.ena = 1'b1;
    transact(4'b0100, 32'h40302010, 32'h04030201, 0, gid, w, s, c, rid);
    chk("ena_rise_wait", 32'(w), 32'd0);
    chk("ena_rise_gnt", 32'(gid), 32'd2);
    chk("ena_rise_sum", 32'(s), 32'h33);

    // Carry counting and saturation at 255.
    for (int i = 0; i < 260; i++) begin
      transact(4'b0100, 32'h00F00000, 32'h00200000, 0, gid, w, s, c, rid);
      m_ovf = (m_ovf + 1 > 255) ? 255 : m_ovf + 1;
      chk("sat_gnt", 32'(gid), 32'd2);
      chk("sat_sum", 32'(s), 32'h10);
      chk("sat_cout", 32'(c), 32'd1);
      chk("sat_ovf", 32'(ifc.ovf_count), 32'(m_ovf));
    end
    chk("sat_final", 32'(ifc.ovf_count), 32'd255);

    // Reset during ISSUE: operation discarded, pointer back to 0.
    ifc.req_a = 32'h40302010; ifc.req_b = 32'h04030201; ifc.req_valid = 4'hF;
    #1;
    chk("mid_rst_pre_gnt", 32'(ifc.req_ready), 32'h8);
    tick();
    rst_n = 1'b0; ifc.req_valid = '0;
    tick();
    chk("mid_rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("mid_rst_ovf", 32'(ifc.ovf_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    end
    transact(4'hF, 32'h40302010, 32'h04030201, 0, gid, w, s, c, rid);
    chk("mid_rst_gnt0", 32'(gid), 32'd0);
    chk("mid_rst_sum", 32'(s), 32'h11);
    m_rr = 1; m_ovf = 0;

    // Randomized traffic against the round-robin reference model.
    for (int n = 0; n < 200; n++) begin
      mask  = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 4) != 0);
      ap    = $urandom;
      bp    = $urandom;
      stall = $urandom_range(0, 3);
      if (mask == 4'b0 || !en) begin
        ifc.ena = en; ifc.req_valid = mask; ifc.req_a = ap; ifc.req_b = bp;
        #1;
        chk("rand_idle_ready", 32'(ifc.req_ready), 32'd0);
        tick();
        chk("rand_idle_rsp", 32'(ifc.rsp_valid), 32'd0);
        ifc.ena = 1'b1; ifc.req_valid = '0;
        $display("[TB] txn mask=%b ena=%0d -> no grant", mask, en);
      end else begin
        eg = -1;
        for (int k = 0; k < N; k++) begin
          if (eg < 0 && mask[(m_rr + k) % N]) eg = (m_rr + k) % N;
        end
        ea   = ap[eg*8 +: 8];
        eb   = bp[eg*8 +: 8];
        full = int'(ea) + int'(eb);
        transact(mask, ap, bp, stall, gid, w, s, c, rid);
        m_ovf = (full >= 256) ? ((m_ovf >= 255) ? 255 : m_ovf + 1) : m_ovf;
        m_rr  = (eg + 1) % N;
        chk("rand_gnt", 32'(gid), 32'(eg));
        chk("rand_rsp_id", 32'(rid), 32'(eg));
        chk("rand_sum", 32'(s), 32'(full % 256));
        chk("rand_cout", 32'(c), 32'(full / 256));
        chk("rand_ovf", 32'(ifc.ovf_count), 32'(m_ovf));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
